// File: rtl/sap_pkg.sv
// Shared constants for the SAP sequencer: opcodes, T-state encodings and
// control-word bit positions used by the microcode ROM, the controller and loaders.
package sap_pkg;

  localparam int OPC_W = 4;
  localparam int TS_W  = 3;

  localparam logic [OPC_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OPC_W-1:0] OP_LDA = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OPC_W-1:0] OP_STA = 4'b0100;
  localparam logic [OPC_W-1:0] OP_LDI = 4'b0101;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b0110;
  localparam logic [OPC_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [TS_W-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  localparam int CW_PC_OUT   = 0;
  localparam int CW_PC_INC   = 1;
  localparam int CW_PC_LOAD  = 2;
  localparam int CW_MAR_LOAD = 3;
  localparam int CW_RAM_OUT  = 4;
  localparam int CW_RAM_LOAD = 5;
  localparam int CW_IR_LOAD  = 6;
  localparam int CW_IR_OUT   = 7;
  localparam int CW_A_LOAD   = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_LOAD   = 10;
  localparam int CW_ALU_OUT  = 11;
  localparam int CW_ALU_SUB  = 12;
  localparam int CW_OUT_LOAD = 13;
  localparam int CW_W        = 14;

  typedef logic [CW_W-1:0] cw_t;

  function automatic cw_t cw_bit(input int idx);
    return cw_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: {opcode, T-state} -> control word plus a flag
// marking the final step of the instruction.
module sap_microcode_rom
  import sap_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  tstate_e          tstate,
  output cw_t              cw,
  output logic             last_step
);

  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    case (tstate)
      T0: cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
      T1: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
          OP_LDI: begin
            cw        = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
            last_step = 1'b1;
          end
          OP_JMP: begin
            cw        = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
            last_step = 1'b1;
          end
          OP_OUT: begin
            cw        = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
            last_step = 1'b1;
          end
          // NOP, HLT and every undefined opcode end here with no strobes
          default: last_step = 1'b1;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            cw        = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
            last_step = 1'b1;
          end
          OP_ADD: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
          OP_SUB: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD) | cw_bit(CW_ALU_SUB);
          OP_STA: begin
            cw        = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_LOAD);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        last_step = 1'b1;
        case (opcode)
          OP_ADD:  cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD);
          OP_SUB:  cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_ALU_SUB);
          default: cw = '0;
        endcase
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/sap_controller.sv
// SAP sequencer: T-state counter, halt flag and enable/reset gating around
// the microcode ROM, with the control word unpacked onto individual strobes.
module sap_controller
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int T_W      = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_pc_out,
  output logic                o_pc_inc,
  output logic                o_pc_load,
  output logic                o_mar_load,
  output logic                o_ram_out,
  output logic                o_ram_load,
  output logic                o_ir_load,
  output logic                o_ir_out,
  output logic                o_a_load,
  output logic                o_a_out,
  output logic                o_b_load,
  output logic                o_alu_out,
  output logic                o_alu_sub,
  output logic                o_out_load,
  output logic                o_halted,
  output logic [T_W-1:0]      o_tstate
);

  tstate_e tstate_reg, tstate_next;
  logic    halted_reg, halted_next;
  cw_t     rom_cw;
  cw_t     cw;
  logic    last_step;

  sap_microcode_rom u_rom (
    .opcode   (i_opcode),
    .tstate   (tstate_reg),
    .cw       (rom_cw),
    .last_step(last_step)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tstate_reg <= T0;
      halted_reg <= 1'b0;
    end else begin
      tstate_reg <= tstate_next;
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    tstate_next = tstate_reg;
    halted_next = halted_reg;
    if (i_enable && !halted_reg) begin
      if (last_step) begin
        tstate_next = T0;
      end else begin
        case (tstate_reg)
          T0:      tstate_next = T1;
          T1:      tstate_next = T2;
          T2:      tstate_next = T3;
          T3:      tstate_next = T4;
          default: tstate_next = T0;
        endcase
      end
      if (tstate_reg == T2 && i_opcode == OP_HLT) halted_next = 1'b1;
    end
  end

  // i_reset is gated in directly so strobes drop before the register settles
  assign cw = (i_enable && !halted_reg && !i_reset) ? rom_cw : '0;

  assign o_pc_out   = cw[CW_PC_OUT];
  assign o_pc_inc   = cw[CW_PC_INC];
  assign o_pc_load  = cw[CW_PC_LOAD];
  assign o_mar_load = cw[CW_MAR_LOAD];
  assign o_ram_out  = cw[CW_RAM_OUT];
  assign o_ram_load = cw[CW_RAM_LOAD];
  assign o_ir_load  = cw[CW_IR_LOAD];
  assign o_ir_out   = cw[CW_IR_OUT];
  assign o_a_load   = cw[CW_A_LOAD];
  assign o_a_out    = cw[CW_A_OUT];
  assign o_b_load   = cw[CW_B_LOAD];
  assign o_alu_out  = cw[CW_ALU_OUT];
  assign o_alu_sub  = cw[CW_ALU_SUB];
  assign o_out_load = cw[CW_OUT_LOAD];
  assign o_halted   = halted_reg;
  assign o_tstate   = tstate_reg;

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: per-opcode expected strobe table, directed
// corner sequences, and random instruction streams with enable stalls.
module tb_sap_controller;
  import sap_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_enable;
  logic [3:0] i_opcode;
  logic o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_load;
  logic o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load;
  logic o_alu_out, o_alu_sub, o_out_load, o_halted;
  logic [2:0] o_tstate;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  sap_controller dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_opcode(i_opcode),
    .o_pc_out(o_pc_out), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load),
    .o_mar_load(o_mar_load), .o_ram_out(o_ram_out), .o_ram_load(o_ram_load),
    .o_ir_load(o_ir_load), .o_ir_out(o_ir_out), .o_a_load(o_a_load),
    .o_a_out(o_a_out), .o_b_load(o_b_load), .o_alu_out(o_alu_out),
    .o_alu_sub(o_alu_sub), .o_out_load(o_out_load), .o_halted(o_halted),
    .o_tstate(o_tstate)
  );

  localparam cw_t M_PC_OUT   = cw_t'(1) << CW_PC_OUT;
  localparam cw_t M_PC_INC   = cw_t'(1) << CW_PC_INC;
  localparam cw_t M_PC_LOAD  = cw_t'(1) << CW_PC_LOAD;
  localparam cw_t M_MAR_LOAD = cw_t'(1) << CW_MAR_LOAD;
  localparam cw_t M_RAM_OUT  = cw_t'(1) << CW_RAM_OUT;
  localparam cw_t M_RAM_LOAD = cw_t'(1) << CW_RAM_LOAD;
  localparam cw_t M_IR_LOAD  = cw_t'(1) << CW_IR_LOAD;
  localparam cw_t M_IR_OUT   = cw_t'(1) << CW_IR_OUT;
  localparam cw_t M_A_LOAD   = cw_t'(1) << CW_A_LOAD;
  localparam cw_t M_A_OUT    = cw_t'(1) << CW_A_OUT;
  localparam cw_t M_B_LOAD   = cw_t'(1) << CW_B_LOAD;
  localparam cw_t M_ALU_OUT  = cw_t'(1) << CW_ALU_OUT;
  localparam cw_t M_ALU_SUB  = cw_t'(1) << CW_ALU_SUB;
  localparam cw_t M_OUT_LOAD = cw_t'(1) << CW_OUT_LOAD;
  localparam cw_t M_F0 = M_PC_OUT | M_MAR_LOAD;
  localparam cw_t M_F1 = M_RAM_OUT | M_IR_LOAD | M_PC_INC;

  // One record per opcode: total cycle count and strobes expected in T0..T4
  typedef struct {
    int  len;
    cw_t cw [5];
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input int len, input cw_t c2, input cw_t c3, input cw_t c4);
    vec_t v;
    v.len   = len;
    v.cw[0] = M_F0;
    v.cw[1] = M_F1;
    v.cw[2] = c2;
    v.cw[3] = c3;
    v.cw[4] = c4;
    return v;
  endfunction

  function automatic cw_t sample_cw();
    cw_t c = '0;
    c[CW_PC_OUT]   = o_pc_out;
    c[CW_PC_INC]   = o_pc_inc;
    c[CW_PC_LOAD]  = o_pc_load;
    c[CW_MAR_LOAD] = o_mar_load;
    c[CW_RAM_OUT]  = o_ram_out;
    c[CW_RAM_LOAD] = o_ram_load;
    c[CW_IR_LOAD]  = o_ir_load;
    c[CW_IR_OUT]   = o_ir_out;
    c[CW_A_LOAD]   = o_a_load;
    c[CW_A_OUT]    = o_a_out;
    c[CW_B_LOAD]   = o_b_load;
    c[CW_ALU_OUT]  = o_alu_out;
    c[CW_ALU_SUB]  = o_alu_sub;
    c[CW_OUT_LOAD] = o_out_load;
    return c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inv();
    int drivers;
    drivers = int'(o_pc_out) + int'(o_ram_out) + int'(o_ir_out) + int'(o_a_out) + int'(o_alu_out);
    check("bus_exclusive", int'(drivers <= 1), 1);
    check("pc_inc_load", int'(o_pc_inc && o_pc_load), 0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Runs one instruction from T0; the opcode is garbage during fetch
  task automatic run_instr(input logic [3:0] op, input bit stalls);
    vec_t v;
    int   n;
    bit   done;
    v    = tbl[op];
    n    = 0;
    done = 1'b0;
    while (!done) begin
      if (stalls && $urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(1, 2);
        i_enable = 1'b0;
        for (int s = 0; s < k; s++) begin
          i_opcode = (n < 2) ? 4'($urandom) : op;
          #1;
          check("stall_tstate", int'(o_tstate), n);
          check("stall_cw", int'(sample_cw()), 0);
          tick();
        end
        i_enable = 1'b1;
      end
      i_opcode = (n < 2) ? 4'($urandom) : op;
      #1;
      check("tstate", int'(o_tstate), n);
      check("cw", int'(sample_cw()), (n < 5) ? int'(v.cw[n]) : 0);
      check_inv();
      tick();
      n++;
      if (o_tstate == 3'd0 || n >= 8) done = 1'b1;
    end
    check("instr_len", n, v.len);
  endtask

  task automatic reset_pulse();
    i_reset = 1'b1;
    #1;
    check("rst_tstate", int'(o_tstate), 0);
    check("rst_cw", int'(sample_cw()), 0);
    check("rst_halted", int'(o_halted), 0);
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = mk(3, '0, '0, '0);
    tbl[OP_LDA] = mk(4, M_IR_OUT | M_MAR_LOAD, M_RAM_OUT | M_A_LOAD, '0);
    tbl[OP_ADD] = mk(5, M_IR_OUT | M_MAR_LOAD, M_RAM_OUT | M_B_LOAD, M_ALU_OUT | M_A_LOAD);
    tbl[OP_SUB] = mk(5, M_IR_OUT | M_MAR_LOAD, M_RAM_OUT | M_B_LOAD | M_ALU_SUB,
                     M_ALU_OUT | M_A_LOAD | M_ALU_SUB);
    tbl[OP_STA] = mk(4, M_IR_OUT | M_MAR_LOAD, M_A_OUT | M_RAM_LOAD, '0);
    tbl[OP_LDI] = mk(3, M_IR_OUT | M_A_LOAD, '0, '0);
    tbl[OP_JMP] = mk(3, M_IR_OUT | M_PC_LOAD, '0, '0);
    tbl[OP_OUT] = mk(3, M_A_OUT | M_OUT_LOAD, '0, '0);

    i_reset  = 1'b1;
    i_enable = 1'b1;
    i_opcode = 4'd0;
    #2;
    check("init_tstate", int'(o_tstate), 0);
    check("init_cw", int'(sample_cw()), 0);
    check("init_halted", int'(o_halted), 0);
    tick();
    tick();
    i_reset = 1'b0;

    // Every opcode except HLT against the table
    for (int i = 0; i < 16; i++) begin
      if (4'(i) != OP_HLT) begin
        run_instr(4'(i), 1'b0);
        check("not_halted", int'(o_halted), 0);
      end
    end

    // HLT: stays parked at T0 with no strobes until reset
    run_instr(OP_HLT, 1'b0);
    for (int c = 0; c < 20; c++) begin
      i_opcode = 4'($urandom);
      #1;
      check("halt_flag", int'(o_halted), 1);
      check("halt_tstate", int'(o_tstate), 0);
      check("halt_cw", int'(sample_cw()), 0);
      tick();
    end
    reset_pulse();
    check("post_halt_flag", int'(o_halted), 0);
    run_instr(OP_NOP, 1'b0);

    // LDA with enable dropped for three cycles in T2
    i_opcode = OP_LDA;
    #1; check("lda_t0", int'(o_tstate), 0); tick();
    #1; check("lda_t1", int'(o_tstate), 1); tick();
    i_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lda_hold_tstate", int'(o_tstate), 2);
      check("lda_hold_cw", int'(sample_cw()), 0);
      tick();
    end
    i_enable = 1'b1;
    #1;
    check("lda_t2_tstate", int'(o_tstate), 2);
    check("lda_t2_cw", int'(sample_cw()), int'(M_IR_OUT | M_MAR_LOAD));
    tick();
    #1;
    check("lda_t3_tstate", int'(o_tstate), 3);
    check("lda_t3_cw", int'(sample_cw()), int'(M_RAM_OUT | M_A_LOAD));
    tick();
    #1;
    check("lda_wrap", int'(o_tstate), 0);

    // Asynchronous reset in the middle of ADD's T3
    i_opcode = OP_ADD;
    tick();
    tick();
    tick();
    #1;
    check("add_t3_tstate", int'(o_tstate), 3);
    check("add_t3_cw", int'(sample_cw()), int'(M_RAM_OUT | M_B_LOAD));
    #2;
    i_reset = 1'b1;
    #1;
    check("async_rst_cw", int'(sample_cw()), 0);
    check("async_rst_tstate", int'(o_tstate), 0);
    tick();
    i_reset = 1'b0;
    #1;
    check("restart_tstate", int'(o_tstate), 0);
    check("restart_cw", int'(sample_cw()), int'(M_F0));
    run_instr(OP_NOP, 1'b0);

    // Random instruction stream with enable stalls
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] op;
      op = 4'($urandom);
      run_instr(op, 1'b1);
      if (op == OP_HLT) begin
        check("rand_halted", int'(o_halted), 1);
        reset_pulse();
      end else begin
        check("rand_not_halted", int'(o_halted), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
